rgb_fade_sequencer: RTL and testbench
=====================================

Name: rgb_fade_sequencer

Overview:
- Command-driven controller for the three RGB PWM channels feeding SB_RGBA_DRV.
- Owns one free-running PWM counter shared by all channels and a per-channel level register.
- Accepts fade commands (channel, target level, step rate) over a valid/ready handshake.
- Ramps each channel's level toward its target, one step per N PWM periods.
- Compare values update only at period boundaries, so there are no mid-period glitches.

Parameters:
- PWM_BITS, 16, width of the shared PWM counter; period is 2^PWM_BITS clocks.
- LEVEL_BITS, 8, width of a channel level/target; constraint LEVEL_BITS <= PWM_BITS <= 2*LEVEL_BITS.
- RATE_BITS, 8, width of the step-rate field and the per-channel period divider.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_chan  in  2  0/1/2 select a channel; 3 broadcasts to all three.
- cmd_level  in  LEVEL_BITS  target level.
- cmd_rate  in  RATE_BITS  PWM periods per level step; 0 means jump.
- busy  out  3  channel i is ramping.
- level  out  3*LEVEL_BITS  current level per channel; channel i occupies [i*LEVEL_BITS +: LEVEL_BITS].
- period_tick  out  1  one-cycle pulse in the last clock of each PWM period.
- pwm_out  out  3  per-channel PWM to RGBnPWM.

Behaviour:
- Reset (RST_N low, async): all registers 0, including counter, levels, targets, dividers, shadow compares, pwm_out, busy, period_tick and cmd_ready.
- cmd_ready is registered. It rises on the first CLK edge after RST_N deasserts and then stays 1; commands are never back-pressured.
- Accept = cmd_valid & cmd_ready, sampled at the CLK edge. On accept, for each addressed channel:
  - target <= cmd_level, rate <= cmd_rate, divider <= 0.
  - If cmd_rate == 0: level <= cmd_level immediately; state IDLE.
  - Else if cmd_level == level: state IDLE, no change.
  - Else: state RAMP, busy bit set on the same edge.
- A new command to a RAMP channel overrides it: restart from the current level, divider cleared.
- PWM counter: increments every clock and wraps from 2^PWM_BITS-1 to 0. period_tick is registered and high while the counter == 0, i.e. the cycle after the max value.
- Per-channel FSM, IDLE/RAMP, evaluated on period_tick edges:
  - RAMP: if divider == rate-1, then divider <= 0 and level moves 1 toward target; otherwise divider += 1.
  - When the updated level equals target: state IDLE, busy clears on that same edge.
- Simultaneous accept and step on the same channel: the command wins and the step is discarded.
- Broadcast (cmd_chan == 3) loads all three channels identically in one cycle.
- Compare mapping: compare = level << (PWM_BITS-LEVEL_BITS), zero-extended to PWM_BITS.
  - Shadow compare is loaded from the current level on the edge where the counter goes max -> 0.
  - The new level therefore affects pwm_out from the following period at the earliest.
- pwm_out[i] <= (counter < shadow_compare[i]), registered, so 1 clock latency from the counter.
  - level 0 gives constant 0.
  - Max level gives high for (2^LEVEL_BITS-1)*2^(PWM_BITS-LEVEL_BITS) clocks per period.
- Levels saturate by construction: steps only move toward the target, so there is no wrap.
- Reset mid-ramp aborts everything and returns to the reset values above.

Optional Feature:
- GAMMA_CORRECT_EN defined: compare = (level*level) >> (2*LEVEL_BITS-PWM_BITS), an unsigned multiply of full width 2*LEVEL_BITS. This gives a perceptually linear fade; level 0 gives 0 and max level gives (2^LEVEL_BITS-1)^2 shifted. It is computed combinationally, is loaded into the shadow register at the same point, and the latency is unchanged.
- Undefined: linear shift mapping as above; no multiplier is inferred.

Test Plan:
- Reset/idle, bench with PWM_BITS=8, LEVEL_BITS=4: hold RST_N low 3 clocks, release -> cmd_ready 0 until the first edge then 1; pwm_out=000, busy=000; period_tick high when counter==0, every 256 clocks.
- Jump: chan=1, level=4, rate=0 -> level[1]=4 on the next edge; from the next period pwm_out[1] is high for exactly 64 of 256 clocks, 1 clock after the counter; other channels stay 0.
- Ramp: chan=0, level=3, rate=2 -> busy[0]=1; level[0] goes 1, 2, 3 on the 2nd, 4th and 6th period_tick; busy[0] clears with the final step; ramp back to 0 decrements likewise.
- Override + collision: ramp chan 2 toward 15 at rate=1, then issue chan=2, level=5 in the period_tick cycle -> the step is dropped, target becomes 5, and the ramp continues toward 5 from the held level.
- Broadcast + async reset: chan=3, level=15, rate=1 -> all busy bits set and all levels equal each period; assert RST_N mid-ramp without a clock edge -> levels, busy and pwm_out 0 immediately.
- GAMMA_CORRECT_EN build, PWM_BITS=8, LEVEL_BITS=4: jump to level 8 -> compare=64, high 64/256 clocks; level 15 -> 225/256.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Three-channel RGB PWM fade controller: shared PWM counter, per-channel level ramps.
// Define GAMMA_CORRECT_EN to use a squared (perceptual) level-to-compare mapping.
module rgb_fade_sequencer #(
    parameter int unsigned PWM_BITS   = 16,
    parameter int unsigned LEVEL_BITS = 8,
    parameter int unsigned RATE_BITS  = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_chan,
    input  logic [LEVEL_BITS-1:0]     cmd_level,
    input  logic [RATE_BITS-1:0]      cmd_rate,
    output logic [2:0]                busy,
    output logic [3*LEVEL_BITS-1:0]   level,
    output logic                      period_tick,
    output logic [2:0]                pwm_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    logic [PWM_BITS-1:0]   r_cnt;
    logic                  r_tick;
    logic                  r_ready;
    logic [2:0]            r_pwm;
    state_t                r_state  [3];
    logic [LEVEL_BITS-1:0] r_level  [3];
    logic [LEVEL_BITS-1:0] r_target [3];
    logic [RATE_BITS-1:0]  r_rate   [3];
    logic [RATE_BITS-1:0]  r_div    [3];
    logic [PWM_BITS-1:0]   r_shadow [3];

    logic                  w_acc;
    logic [2:0]            w_sel;
    logic [LEVEL_BITS-1:0] w_step   [3];
    logic [PWM_BITS-1:0]   w_cmp    [3];

`ifdef GAMMA_CORRECT_EN
    localparam int unsigned SQ_SHIFT = 2*LEVEL_BITS - PWM_BITS;
    logic [2*LEVEL_BITS-1:0] w_sq [3];
`endif

    assign w_acc       = cmd_valid & r_ready;
    assign cmd_ready   = r_ready;
    assign period_tick = r_tick;
    assign pwm_out     = r_pwm;

    always_comb begin
        level = '0;
        busy  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_sel[i]  = w_acc && ((cmd_chan == 2'd3) || (cmd_chan == 2'(i)));
            w_step[i] = (r_target[i] > r_level[i]) ? r_level[i] + LEVEL_BITS'(1)
                                                   : r_level[i] - LEVEL_BITS'(1);
`ifdef GAMMA_CORRECT_EN
            w_sq[i]   = (2*LEVEL_BITS)'(r_level[i]) * (2*LEVEL_BITS)'(r_level[i]);
            w_cmp[i]  = PWM_BITS'(w_sq[i] >> SQ_SHIFT);
`else
            w_cmp[i]  = PWM_BITS'(r_level[i]) << (PWM_BITS - LEVEL_BITS);
`endif
            level[i*LEVEL_BITS +: LEVEL_BITS] = r_level[i];
            busy[i]   = (r_state[i] == S_RAMP);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
            r_pwm   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_state[i]  <= S_IDLE;
                r_level[i]  <= '0;
                r_target[i] <= '0;
                r_rate[i]   <= '0;
                r_div[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_ready <= 1'b1;
            r_cnt   <= r_cnt + PWM_BITS'(1);
            r_tick  <= (r_cnt == '1);
            for (int unsigned i = 0; i < 3; i++) begin
                // An accepted command takes priority over a coincident ramp step.
                if (w_sel[i]) begin
                    r_target[i] <= cmd_level;
                    r_rate[i]   <= cmd_rate;
                    r_div[i]    <= '0;
                    if (cmd_rate == '0) begin
                        r_level[i] <= cmd_level;
                        r_state[i] <= S_IDLE;
                    end else if (cmd_level == r_level[i]) begin
                        r_state[i] <= S_IDLE;
                    end else begin
                        r_state[i] <= S_RAMP;
                    end
                end else if (r_tick && (r_state[i] == S_RAMP)) begin
                    if (r_div[i] == r_rate[i] - RATE_BITS'(1)) begin
                        r_div[i]   <= '0;
                        r_level[i] <= w_step[i];
                        if (w_step[i] == r_target[i])
                            r_state[i] <= S_IDLE;
                    end else begin
                        r_div[i] <= r_div[i] + RATE_BITS'(1);
                    end
                end
                // Shadow compare only changes at the period boundary.
                if (r_cnt == '1)
                    r_shadow[i] <= w_cmp[i];
                r_pwm[i] <= (r_cnt < r_shadow[i]);
            end
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with PWM_BITS=8, LEVEL_BITS=4.
// Expected compare values follow GAMMA_CORRECT_EN when the build defines it.
module tb_rgb_fade_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_chan;
    logic [3:0]  cmd_level;
    logic [7:0]  cmd_rate;
    logic [2:0]  busy;
    logic [11:0] level;
    logic        period_tick;
    logic [2:0]  pwm_out;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    rgb_fade_sequencer #(
        .PWM_BITS  (8),
        .LEVEL_BITS(4),
        .RATE_BITS (8)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_level  (cmd_level),
        .cmd_rate   (cmd_rate),
        .busy       (busy),
        .level      (level),
        .period_tick(period_tick),
        .pwm_out    (pwm_out)
    );

    always #5 CLK = ~CLK;

    function automatic int cmp_of(input int lvl);
`ifdef GAMMA_CORRECT_EN
        return lvl * lvl;
`else
        return lvl * 16;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic send(input int ch, input int lv, input int rt);
        cmd_valid = 1'b1;
        cmd_chan  = 2'(ch);
        cmd_level = 4'(lv);
        cmd_rate  = 8'(rt);
        step();
        cmd_valid = 1'b0;
    endtask

    function automatic int lvl(input int ch);
        return int'(level[ch*4 +: 4]);
    endfunction

    initial begin
        int bad;
        int highs;
        RST_N     = 1'b0;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_level = '0;
        cmd_rate  = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc   = 0;
        check("ready_before_edge", int'(cmd_ready), 0);
        check("pwm_reset", int'(pwm_out), 0);
        check("busy_reset", int'(busy), 0);
        check("level_reset", int'(level), 0);
        step();
        check("ready_after_edge", int'(cmd_ready), 1);
        step_to(255);
        check("tick_low_255", int'(period_tick), 0);
        step();
        check("tick_high_256", int'(period_tick), 1);
        step();
        check("tick_low_257", int'(period_tick), 0);

        // Jump on channel 1; new compare takes effect from the next period
        send(1, 4, 0);
        check("jump_level1", lvl(1), 4);
        check("jump_busy", int'(busy), 0);
        bad   = 0;
        highs = 0;
        while (cyc < 768) begin
            step();
            if (pwm_out[1] !== ((cyc >= 513) && (((cyc - 1) % 256) < cmp_of(4)))) bad++;
            if (pwm_out[0] !== 1'b0 || pwm_out[2] !== 1'b0) bad++;
            if (cyc >= 513 && pwm_out[1] === 1'b1) highs++;
        end
        check("jump_pwm_pattern_errs", bad, 0);
        check("jump_pwm_high_count", highs, cmp_of(4));

        // Ramp channel 0 up to 3 at rate 2, then back down to 0
        step_to(770);
        send(0, 3, 2);
        check("ramp_busy_set", int'(busy), 1);
        check("ramp_level_start", lvl(0), 0);
        step_to(1280);
        check("ramp_lvl_before_tick2", lvl(0), 0);
        step();
        check("ramp_lvl_tick2", lvl(0), 1);
        step_to(1793);
        check("ramp_lvl_tick4", lvl(0), 2);
        step_to(2304);
        check("ramp_busy_before_end", int'(busy[0]), 1);
        step();
        check("ramp_lvl_tick6", lvl(0), 3);
        check("ramp_busy_clear", int'(busy[0]), 0);
        send(0, 0, 2);
        check("down_busy_set", int'(busy[0]), 1);
        step_to(2817);
        check("down_lvl_2", lvl(0), 2);
        step_to(3840);
        check("down_lvl_1", lvl(0), 1);
        step();
        check("down_lvl_0", lvl(0), 0);
        check("down_busy_clear", int'(busy[0]), 0);

        // Override in the period_tick cycle drops the coincident step
        send(2, 15, 1);
        check("ovr_busy_set", int'(busy), 4);
        step_to(4864);
        check("ovr_tick_cycle", int'(period_tick), 1);
        check("ovr_lvl_before", lvl(2), 3);
        send(2, 5, 1);
        check("ovr_step_dropped", lvl(2), 3);
        check("ovr_still_busy", int'(busy[2]), 1);
        step_to(5121);
        check("ovr_lvl_4", lvl(2), 4);
        step_to(5377);
        check("ovr_lvl_5", lvl(2), 5);
        check("ovr_busy_clear", int'(busy[2]), 0);

        // Broadcast jump to 0, then broadcast ramp to 15
        step();
        send(3, 0, 0);
        check("bc_jump_levels", int'(level), 0);
        send(3, 15, 1);
        check("bc_busy_all", int'(busy), 7);
        step_to(5889);
        check("bc_levels_2", int'(level), 12'h222);
        step_to(5900);
        check("bc_pwm_mid", int'(pwm_out), (11 < cmp_of(1)) ? 7 : 0);

        // Asynchronous reset mid-ramp, no clock edge
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_level", int'(level), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_ready", int'(cmd_ready), 0);
        check("arst_tick", int'(period_tick), 0);

        // Level-to-compare mapping at mid and max levels
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc   = 0;
        step();
        check("rel_ready", int'(cmd_ready), 1);
        send(0, 8, 0);
        highs = 0;
        step_to(256);
        while (cyc < 512) begin
            step();
            if (pwm_out[0] === 1'b1) highs++;
        end
        check("map_lvl8_high", highs, cmp_of(8));
        send(0, 15, 0);
        highs = 0;
        step_to(768);
        while (cyc < 1024) begin
            step();
            if (pwm_out[0] === 1'b1) highs++;
        end
        check("map_lvl15_high", highs, cmp_of(15));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
